exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//   Execute stage plus EXE/MEM pipeline register of the 16-bit five-stage core. Consumes the ID/EXE
//   latch outputs (op1, op2, opn, pc, memory/writeback controls), computes the ALU result and resolves
//   branches/jumps. Registers everything for the MEM stage. On a taken branch it redirects fetch and
//   runs a small flush FSM that squashes wrong-path instructions and drives hold into IF/ID and ID/EXE.
// PARAMETERS
//   DATA_W        16   datapath width (`RegValue)
//   ADDR_W        4    register address width (`RegAddr)
//   FLUSH_CYCLES  2    wrong-path instructions squashed after a taken branch (1..7)
//   NOP_OPN       16'h0800  opcode emitted for a bubble
// PORTS
//   clk                 in   1       single clock, rising edge
//   rst                 in   1       synchronous, active-high reset
//   mem_stall           in   1       MEM stage busy; freeze this stage
//   op1, op2            in   DATA_W  operands from ID/EXE
//   opn, pc             in   DATA_W  instruction word; pc = address of this instruction + 1
//   mem_write_value     in   DATA_W  store data from ID/EXE
//   mem_write, mem_read, reg_write  in 1  controls from ID/EXE
//   reg_addr            in   ADDR_W  destination register
//   alu_result          out  DATA_W  registered result / memory address
//   mem_write_value_out out  DATA_W  registered store data
//   mem_write_out, mem_read_out, reg_write_out  out 1  registered controls
//   reg_addr_out        out  ADDR_W  registered destination
//   opn_out             out  DATA_W  registered instruction word
//   branch_taken        out  1       one-cycle pulse: redirect fetch
//   branch_target       out  DATA_W  valid while branch_taken=1
//   flush               out  1       high in state FLUSH; drives hold of IF/ID and ID/EXE
// BEHAVIOUR
//   - Reset: all outputs 0 except opn_out=NOP_OPN; state=RUN; counter=0. Reset mid-FLUSH -> RUN, flush=0 next cycle.
//   - Latency: 1 cycle input->outputs. mem_stall=1: every output register, state and counter hold;
//     branch_taken forced 0 that cycle; a branch presented during stall resolves on first unstalled cycle.
//   - ALU by opn[15:11] (all 16-bit wrap-around, no flags):
//     01001 ADDIU, 01101 LI, 01111 MOVE -> op1+op2 | 11100: [1:0]=01 op1+op2, [1:0]=11 op1-op2
//     11101: [4:0]=01100 op1&op2, [4:0]=01101 op1|op2, [7:0]=0 JR (result 0)
//     00110 [1:0]=00 SLL: op1<<op2[2:0], shift amount 0 means 8 | 10011/11011 LW/SW: op1+op2
//     any other opcode (incl. NOP 00001): result 0, controls passed unchanged.
//   - Branch resolution (RUN, not stalled):
//     00010 B: taken, target=pc+sext(opn[10:0]) | 00100 BEQZ: taken iff op1==0, target=pc+sext(opn[7:0])
//     00101 BNEZ: taken iff op1!=0, same target | 11101 & opn[7:0]==0 JR: taken, target=op1.
//     Taken -> branch_taken=1 and branch_target registered next cycle; state->FLUSH, counter=FLUSH_CYCLES.
//     The branch itself passes to MEM as a normal instruction (reg_write as supplied).
//   - FSM RUN/FLUSH. In FLUSH: flush=1; each unstalled cycle the incoming instruction is squashed
//     (mem_write_out, mem_read_out, reg_write_out=0, reg_addr_out=0, opn_out=NOP_OPN, alu_result=0),
//     its branch is ignored, counter decrements; counter reaching 0 -> RUN, flush=0 the cycle after
//     the last squash. flush asserts same edge as branch_taken.
//   - Not-taken BEQZ/BNEZ: no pulse, no flush, state stays RUN.
// TESTING
//   1 ADDIU op1=16'h7FFF op2=16'h0001 -> alu_result=16'h8000 one cycle later, reg_write_out follows input.
//   2 SUBU op1=0 op2=1 -> alu_result=16'hFFFF; SLL op1=16'h0003 op2=0 -> 16'h0300.
//   3 BNEZ opn=16'h28FE, op1=5, pc=16'h0010 -> branch_taken=1 1 cycle, target=16'h000E, flush=1
//     for 2 cycles; the 2 following ADDU with reg_write=1 exit with reg_write_out=0, opn_out=16'h0800.
//   4 BEQZ op1=1 -> branch_taken=0, flush=0, next instruction passes unmodified.
//   5 BEQZ op1=0 with mem_stall=1 for 3 cycles -> outputs frozen, branch_taken=0; pulse on first cycle
//     after release, then normal 2-cycle flush.
//   6 rst=1 during second FLUSH cycle -> next edge: flush=0, branch_taken=0, opn_out=16'h0800, all controls 0.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage and EXE/MEM pipeline register of the 16-bit five-stage core.
// Computes the ALU result, resolves branches/jumps and squashes wrong-path instructions.
module exe_stage #(
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       ADDR_W       = 4,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_OPN      = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] opn,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] mem_write_value,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_write_value_out,
  output logic              mem_write_out,
  output logic              mem_read_out,
  output logic              reg_write_out,
  output logic [ADDR_W-1:0] reg_addr_out,
  output logic [DATA_W-1:0] opn_out,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush
);

  localparam int unsigned CntW = 3;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mwv_q, mwv_d;
  logic              mw_q, mw_d;
  logic              mr_q, mr_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] opn_q, opn_d;

  logic [4:0]        opcode;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        shamt;
  logic              br_hit;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] sext11;
  logic [DATA_W-1:0] sext8;

  assign opcode = opn[15:11];
  assign sext11 = {{(DATA_W-11){opn[10]}}, opn[10:0]};
  assign sext8  = {{(DATA_W-8){opn[7]}}, opn[7:0]};
  // A zero shift field encodes a shift by eight.
  assign shamt  = (op2[2:0] == 3'd0) ? 4'd8 : {1'b0, op2[2:0]};

  always_comb begin
    alu_res = '0;
    case (opcode)
      5'b01001, 5'b01101, 5'b01111: alu_res = op1 + op2;
      5'b10011, 5'b11011:           alu_res = op1 + op2;
      5'b11100: begin
        if (opn[1:0] == 2'b01)      alu_res = op1 + op2;
        else if (opn[1:0] == 2'b11) alu_res = op1 - op2;
      end
      5'b11101: begin
        if (opn[4:0] == 5'b01100)      alu_res = op1 & op2;
        else if (opn[4:0] == 5'b01101) alu_res = op1 | op2;
      end
      5'b00110: begin
        if (opn[1:0] == 2'b00) alu_res = op1 << shamt;
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_hit    = 1'b0;
    br_target = pc + sext8;
    case (opcode)
      5'b00010: begin
        br_hit    = 1'b1;
        br_target = pc + sext11;
      end
      5'b00100: br_hit = (op1 == '0);
      5'b00101: br_hit = (op1 != '0);
      5'b11101: begin
        if (opn[7:0] == 8'd0) begin
          br_hit    = 1'b1;
          br_target = op1;
        end
      end
      default: br_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    taken_d  = 1'b0;
    target_d = target_q;
    alu_d    = alu_res;
    mwv_d    = mem_write_value;
    mw_d     = mem_write;
    mr_d     = mem_read;
    rw_d     = reg_write;
    ra_d     = reg_addr;
    opn_d    = opn;
    unique case (state_q)
      StRun: begin
        if (br_hit) begin
          taken_d  = 1'b1;
          target_d = br_target;
          state_d  = StFlush;
          cnt_d    = CntW'(FLUSH_CYCLES);
        end
      end
      StFlush: begin
        // Wrong-path instruction: becomes a bubble and its branch is ignored.
        alu_d = '0;
        mw_d  = 1'b0;
        mr_d  = 1'b0;
        rw_d  = 1'b0;
        ra_d  = '0;
        opn_d = NOP_OPN;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      alu_q    <= '0;
      mwv_q    <= '0;
      mw_q     <= 1'b0;
      mr_q     <= 1'b0;
      rw_q     <= 1'b0;
      ra_q     <= '0;
      opn_q    <= NOP_OPN;
    end else if (mem_stall) begin
      // Everything freezes except the redirect pulse, which must not repeat.
      taken_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      alu_q    <= alu_d;
      mwv_q    <= mwv_d;
      mw_q     <= mw_d;
      mr_q     <= mr_d;
      rw_q     <= rw_d;
      ra_q     <= ra_d;
      opn_q    <= opn_d;
    end
  end

  assign alu_result          = alu_q;
  assign mem_write_value_out = mwv_q;
  assign mem_write_out       = mw_q;
  assign mem_read_out        = mr_q;
  assign reg_write_out       = rw_q;
  assign reg_addr_out        = ra_q;
  assign opn_out             = opn_q;
  assign branch_taken        = taken_q;
  assign branch_target       = target_q;
  assign flush               = (state_q == StFlush);

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU ops, branches, flush, stall and reset.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_stall;
  logic [15:0] op1, op2, opn, pc, mem_write_value;
  logic        mem_write, mem_read, reg_write;
  logic [3:0]  reg_addr;
  logic [15:0] alu_result, mem_write_value_out, opn_out, branch_target;
  logic        mem_write_out, mem_read_out, reg_write_out, branch_taken, flush;
  logic [3:0]  reg_addr_out;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_stall           (mem_stall),
    .op1                 (op1),
    .op2                 (op2),
    .opn                 (opn),
    .pc                  (pc),
    .mem_write_value     (mem_write_value),
    .mem_write           (mem_write),
    .mem_read            (mem_read),
    .reg_write           (reg_write),
    .reg_addr            (reg_addr),
    .alu_result          (alu_result),
    .mem_write_value_out (mem_write_value_out),
    .mem_write_out       (mem_write_out),
    .mem_read_out        (mem_read_out),
    .reg_write_out       (reg_write_out),
    .reg_addr_out        (reg_addr_out),
    .opn_out             (opn_out),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .flush               (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] p, input logic rw);
    opn = o; op1 = a; op2 = b; pc = p; reg_write = rw;
    mem_write = 1'b0; mem_read = 1'b0; reg_addr = 4'd7; mem_write_value = 16'h5A5A;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_stall = 1'b0;
    drive(16'h4801, 16'h1111, 16'h2222, 16'h0000, 1'b1);
    tick(); tick();
    checks++; if (opn_out !== 16'h0800) begin errors++; $display("FAIL reset_opn got %h exp 0800", opn_out); end
    checks++; if (alu_result !== 16'h0000) begin errors++; $display("FAIL reset_alu got %h exp 0000", alu_result); end
    checks++; if ({mem_write_out, mem_read_out, reg_write_out} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {mem_write_out, mem_read_out, reg_write_out}); end
    checks++; if ({branch_taken, flush} !== 2'b00) begin errors++; $display("FAIL reset_br got %b exp 00", {branch_taken, flush}); end
    checks++; if (branch_target !== 16'h0000 || reg_addr_out !== 4'd0 || mem_write_value_out !== 16'h0000) begin errors++; $display("FAIL reset_regs got %h %h %h exp 0", branch_target, reg_addr_out, mem_write_value_out); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [15:0] v_opn [10] = '{16'h4801, 16'hE003, 16'h3000, 16'h3000, 16'hE80C,
                               16'hE80D, 16'h9800, 16'h0800, 16'hE001, 16'h6800};
    logic [15:0] v_a   [10] = '{16'h7FFF, 16'h0000, 16'h0003, 16'h0003, 16'hF0F0,
                               16'hF0F0, 16'h0100, 16'h0005, 16'hFFFF, 16'h0000};
    logic [15:0] v_b   [10] = '{16'h0001, 16'h0001, 16'h0000, 16'h0002, 16'hFF00,
                               16'hFF00, 16'h0005, 16'h0005, 16'h0002, 16'h1234};
    logic [15:0] v_exp [10] = '{16'h8000, 16'hFFFF, 16'h0300, 16'h000C, 16'hF000,
                               16'hFFF0, 16'h0105, 16'h0000, 16'h0001, 16'h1234};
    for (int i = 0; i < 10; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      opn = v_opn[i]; op1 = v_a[i]; op2 = v_b[i]; pc = 16'h0100;
      mem_write = iv[0]; mem_read = iv[1]; reg_write = ~iv[2]; reg_addr = iv;
      mem_write_value = 16'hA000 + 16'(i);
      tick();
      checks++; if (alu_result !== v_exp[i]) begin errors++; $display("FAIL alu_%0d got %h exp %h", i, alu_result, v_exp[i]); end
      checks++; if ({mem_write_out, mem_read_out, reg_write_out, reg_addr_out} !== {iv[0], iv[1], ~iv[2], iv}) begin errors++; $display("FAIL ctrl_%0d got %b%b%b %h", i, mem_write_out, mem_read_out, reg_write_out, reg_addr_out); end
      checks++; if (opn_out !== v_opn[i] || mem_write_value_out !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL pass_%0d got %h %h", i, opn_out, mem_write_value_out); end
      checks++; if ({branch_taken, flush} !== 2'b00) begin errors++; $display("FAIL nobr_%0d got %b exp 00", i, {branch_taken, flush}); end
    end
  endtask

  task automatic test_branch_taken();
    drive(16'h28FE, 16'h0005, 16'h0000, 16'h0010, 1'b0);
    tick();
    checks++; if ({branch_taken, flush} !== 2'b11) begin errors++; $display("FAIL bnez_pulse got %b exp 11", {branch_taken, flush}); end
    checks++; if (branch_target !== 16'h000E) begin errors++; $display("FAIL bnez_target got %h exp 000E", branch_target); end
    checks++; if (opn_out !== 16'h28FE || reg_write_out !== 1'b0) begin errors++; $display("FAIL bnez_pass got %h %b", opn_out, reg_write_out); end
    drive(16'hE001, 16'h0001, 16'h0002, 16'h0011, 1'b1);
    tick();
    checks++; if ({branch_taken, flush} !== 2'b01) begin errors++; $display("FAIL flush1 got %b exp 01", {branch_taken, flush}); end
    checks++; if (reg_write_out !== 1'b0 || opn_out !== 16'h0800 || alu_result !== 16'h0000 || reg_addr_out !== 4'd0) begin errors++; $display("FAIL squash1 got %b %h %h %h", reg_write_out, opn_out, alu_result, reg_addr_out); end
    // A branch on the wrong path must be ignored.
    drive(16'h1005, 16'h0001, 16'h0002, 16'h0012, 1'b1);
    tick();
    checks++; if ({branch_taken, flush} !== 2'b00) begin errors++; $display("FAIL flush2 got %b exp 00", {branch_taken, flush}); end
    checks++; if (reg_write_out !== 1'b0 || opn_out !== 16'h0800) begin errors++; $display("FAIL squash2 got %b %h", reg_write_out, opn_out); end
    drive(16'hE001, 16'h0001, 16'h0002, 16'h000E, 1'b1);
    tick();
    checks++; if (reg_write_out !== 1'b1 || opn_out !== 16'hE001 || alu_result !== 16'h0003) begin errors++; $display("FAIL after_flush got %b %h %h", reg_write_out, opn_out, alu_result); end
    checks++; if ({branch_taken, flush} !== 2'b00) begin errors++; $display("FAIL after_flush_br got %b exp 00", {branch_taken, flush}); end
  endtask

  task automatic test_not_taken();
    drive(16'h2003, 16'h0001, 16'h0000, 16'h0040, 1'b0);
    tick();
    checks++; if ({branch_taken, flush} !== 2'b00 || opn_out !== 16'h2003) begin errors++; $display("FAIL beqz_nt got %b %h", {branch_taken, flush}, opn_out); end
    drive(16'h4801, 16'h0010, 16'h0020, 16'h0041, 1'b1);
    tick();
    checks++; if (reg_write_out !== 1'b1 || opn_out !== 16'h4801 || alu_result !== 16'h0030 || flush !== 1'b0) begin errors++; $display("FAIL nt_next got %b %h %h %b", reg_write_out, opn_out, alu_result, flush); end
  endtask

  task automatic test_stall();
    drive(16'h4801, 16'h0100, 16'h0023, 16'h001F, 1'b1);
    tick();
    mem_stall = 1'b1;
    drive(16'h2005, 16'h0000, 16'h0000, 16'h0020, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (opn_out !== 16'h4801 || alu_result !== 16'h0123 || reg_write_out !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d got %h %h %b", i, opn_out, alu_result, reg_write_out); end
      checks++; if ({branch_taken, flush} !== 2'b00) begin errors++; $display("FAIL stall_br_%0d got %b exp 00", i, {branch_taken, flush}); end
    end
    mem_stall = 1'b0;
    tick();
    checks++; if ({branch_taken, flush} !== 2'b11 || branch_target !== 16'h0025) begin errors++; $display("FAIL stall_pulse got %b %h exp 11 0025", {branch_taken, flush}, branch_target); end
    checks++; if (opn_out !== 16'h2005) begin errors++; $display("FAIL stall_bpass got %h exp 2005", opn_out); end
    // Stall inside the flush window: counter holds, pulse does not repeat.
    mem_stall = 1'b1;
    drive(16'hE001, 16'h0001, 16'h0001, 16'h0021, 1'b1);
    tick();
    checks++; if ({branch_taken, flush} !== 2'b01 || opn_out !== 16'h2005) begin errors++; $display("FAIL flush_stall got %b %h", {branch_taken, flush}, opn_out); end
    mem_stall = 1'b0;
    tick();
    checks++; if (flush !== 1'b1 || opn_out !== 16'h0800 || reg_write_out !== 1'b0) begin errors++; $display("FAIL stall_sq1 got %b %h %b", flush, opn_out, reg_write_out); end
    tick();
    checks++; if (flush !== 1'b0 || opn_out !== 16'h0800 || reg_write_out !== 1'b0) begin errors++; $display("FAIL stall_sq2 got %b %h %b", flush, opn_out, reg_write_out); end
  endtask

  task automatic test_reset_mid_flush();
    drive(16'h1002, 16'h0000, 16'h0000, 16'h0030, 1'b0);
    tick();
    checks++; if ({branch_taken, flush} !== 2'b11 || branch_target !== 16'h0032) begin errors++; $display("FAIL b_pulse got %b %h", {branch_taken, flush}, branch_target); end
    drive(16'hE001, 16'h0001, 16'h0001, 16'h0031, 1'b1);
    mem_write = 1'b1; mem_read = 1'b1;
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL flush_second got %b exp 1", flush); end
    rst = 1'b1;
    tick();
    checks++; if ({branch_taken, flush} !== 2'b00 || opn_out !== 16'h0800) begin errors++; $display("FAIL rst_flush got %b %h", {branch_taken, flush}, opn_out); end
    checks++; if ({mem_write_out, mem_read_out, reg_write_out} !== 3'b000 || reg_addr_out !== 4'd0) begin errors++; $display("FAIL rst_flush_ctrl got %b %h", {mem_write_out, mem_read_out, reg_write_out}, reg_addr_out); end
    rst = 1'b0;
    drive(16'h4801, 16'h0002, 16'h0003, 16'h0050, 1'b1);
    tick();
    checks++; if (reg_write_out !== 1'b1 || opn_out !== 16'h4801 || alu_result !== 16'h0005 || flush !== 1'b0) begin errors++; $display("FAIL post_rst got %b %h %h %b", reg_write_out, opn_out, alu_result, flush); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch_taken();
    test_not_taken();
    test_stall();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
